// File: rtl/bmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// bmem_arbiter_if
// Bus bundle between NUM_CH burst requesters, the arbiter and one memory port.
//
// Signals
//   ch_addr   requester -> arbiter  per-channel burst address, ch i at [i*ADDR_W +: ADDR_W]
//   ch_read   requester -> arbiter  per-channel read request (level)
//   ch_write  requester -> arbiter  per-channel write request (level)
//   ch_wdata  requester -> arbiter  per-channel write beat, ch i at [i*DATA_W +: DATA_W]
//   ch_rdata  arbiter -> requester  read beat data, broadcast
//   ch_resp   arbiter -> requester  per-channel beat acknowledge
//   mem_addr  arbiter -> memory     burst address
//   mem_read  arbiter -> memory     read request
//   mem_write arbiter -> memory     write request
//   mem_wdata arbiter -> memory     write beat of granted channel
//   mem_rdata memory -> arbiter     read beat data
//   mem_resp  memory -> arbiter     beat acknowledge, one pulse per beat
//
// Handshake: a requester raises ch_read or ch_write and holds it (with a
// stable ch_addr) until it has seen BURST_LEN ch_resp pulses. Each ch_resp
// pulse is one beat transferred on that rising edge: read data is valid on
// ch_rdata in that cycle, and the requester presents its next write beat on
// ch_wdata after the edge. The memory side mirrors this: mem_read/mem_write
// stay asserted for the whole burst and mem_resp acknowledges one beat.
//
// Modports
//   slave  : the arbiter's view
//   master : the requesters + memory model's view (testbench)
// ---------------------------------------------------------------------------
interface bmem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [DATA_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_read;
  logic                     mem_write;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_resp;

  modport slave (
    input  ch_addr, ch_read, ch_write, ch_wdata, mem_rdata, mem_resp,
    output ch_rdata, ch_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output ch_addr, ch_read, ch_write, ch_wdata, mem_rdata, mem_resp,
    input  ch_rdata, ch_resp, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/bmem_arbiter.sv
// ---------------------------------------------------------------------------
// bmem_arbiter
// Round-robin arbiter that multiplexes NUM_CH burst requesters onto a single
// memory port. One burst of BURST_LEN beats is served per grant; after each
// burst the priority pointer moves to the channel after the one just served.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-low reset
//   bus        bmem_arbiter_if.slave (requester and memory signals)
//   err        sticky protocol-error flag (cleared only by reset)
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//   dbg_ptr    current round-robin priority pointer
//
// Protocol errors that set err:
//   - granted channel asserts read and write together (a read is performed)
//   - granted channel drops its request before the burst finished
//   - mem_resp while not in BUSY (the pulse is otherwise ignored)
// ---------------------------------------------------------------------------
module bmem_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4,
  localparam int GNT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  bmem_arbiter_if.slave    bus,
  output logic             err,
  output logic [1:0]       dbg_state,
  output logic [GNT_W-1:0] dbg_ptr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GNT_W-1:0]    r_gnt;
  logic [GNT_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_err;

  logic [NUM_CH-1:0]   w_req;
  logic [NUM_CH-1:0]   w_resp;
  logic                w_found;
  logic [GNT_W-1:0]    w_pick;
  logic [GNT_W:0]      w_sum;
  logic [GNT_W-1:0]    w_idx;
  logic                w_last_beat;
  logic                w_pick_rd;
  logic                w_pick_wr;

  logic [ADDR_W-1:0]   w_addr_arr  [NUM_CH];
  logic [DATA_W-1:0]   w_wdata_arr [NUM_CH];

  // Unpack the flat per-channel buses so channels can be indexed by r_gnt.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_addr_arr[g]  = bus.ch_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = bus.ch_wdata[g*DATA_W +: DATA_W];
  end

  assign w_req       = bus.ch_read | bus.ch_write;
  assign w_last_beat = (r_cnt == CNT_W'(BURST_LEN - 1));
  assign w_pick_rd   = bus.ch_read[w_pick];
  assign w_pick_wr   = bus.ch_write[w_pick];

  // Round-robin search: first requesting channel at or after r_ptr.
  // The sum is kept one bit wider so the modulo wrap also works when NUM_CH
  // is not a power of two.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = {1'b0, r_ptr} + (GNT_W+1)'(k);
      if (w_sum >= (GNT_W+1)'(NUM_CH)) begin
        w_sum = w_sum - (GNT_W+1)'(NUM_CH);
      end
      w_idx = w_sum[GNT_W-1:0];
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // FSM next state and beat routing; ch_resp is only ever driven in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_resp      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_resp) begin
          w_resp[r_gnt] = 1'b1;
          if (w_last_beat) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers. mem_read/mem_write are captured at grant so they are
  // valid the cycle after the request is sampled, held through BUSY, and
  // dropped on the last beat so they read 0 while in DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.mem_resp) begin
            r_err <= 1'b1;
          end
          if (w_found) begin
            r_gnt       <= w_pick;
            r_mem_addr  <= w_addr_arr[w_pick];
            r_cnt       <= '0;
            // Read wins when both are requested.
            r_mem_read  <= w_pick_rd;
            r_mem_write <= w_pick_wr & ~w_pick_rd;
            if (w_pick_rd && w_pick_wr) begin
              r_err <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          // Requester must hold its request through the last beat; the
          // burst still completes if it does not.
          if (!w_req[r_gnt]) begin
            r_err <= 1'b1;
          end
          if (bus.mem_resp) begin
            if (w_last_beat) begin
              r_cnt       <= '0;
              r_mem_read  <= 1'b0;
              r_mem_write <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (bus.mem_resp) begin
            r_err <= 1'b1;
          end
          r_ptr <= (r_gnt == GNT_W'(NUM_CH - 1)) ? '0 : r_gnt + GNT_W'(1);
        end
        default: begin
          r_err <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ch_resp   = w_resp;
  assign bus.ch_rdata  = bus.mem_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_wdata = w_wdata_arr[r_gnt];
  assign err           = r_err;
  assign dbg_state     = r_state;
  assign dbg_ptr       = r_ptr;

endmodule
